// File: rtl/padding_stream_ctrl.sv
// Streams a zero-padded D x (H+2P) x (W+2P) feature map in channel/row/column order.
// Interior pixels are fetched from a synchronous feature buffer and border pixels are zeros.
module padding_stream_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int H          = 10,
    parameter int W          = 10,
    parameter int P          = 2,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [2:0]            dbg_state
);

    // Handshake: a beat transfers on a rising edge where out_valid & out_ready.
    // Once out_valid rises, out_data and out_last hold until that transfer.

    localparam int HP   = H + 2 * P;
    localparam int WP   = W + 2 * P;
    localparam int MAXD = (HP > WP) ? HP : WP;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int CCW  = (D > 1) ? $clog2(D) : 1;

    localparam logic [CW-1:0]  P_C    = CW'(P);
    localparam logic [CW-1:0]  Y_END  = CW'(P + H);
    localparam logic [CW-1:0]  X_END  = CW'(P + W);
    localparam logic [CW-1:0]  Y_LAST = CW'(HP - 1);
    localparam logic [CW-1:0]  X_LAST = CW'(WP - 1);
    localparam logic [CCW-1:0] C_LAST = CCW'(D - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [CCW-1:0]        c, c_n;
    logic [CW-1:0]         y, y_n;
    logic [CW-1:0]         x, x_n;
    logic [ADDR_WIDTH-1:0] addr, addr_n;
    logic                  valid_n;
    logic                  last_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  interior;
    logic                  last_pix;

    // Lower bounds use "+1 >" so that P=0 does not collapse into an always-true compare.
    assign interior = ((y + CW'(1)) > P_C) && (y < Y_END) &&
                      ((x + CW'(1)) > P_C) && (x < X_END);
    assign last_pix = (c == C_LAST) && (y == Y_LAST) && (x == X_LAST);

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign rd_addr   = addr;
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        c_n     = c;
        y_n     = y;
        x_n     = x;
        addr_n  = addr;
        valid_n = out_valid;
        data_n  = out_data;
        last_n  = out_last;
        rd_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ISSUE;
                    c_n     = '0;
                    y_n     = '0;
                    x_n     = '0;
                    addr_n  = '0;
                end
            end
            S_ISSUE: begin
                if (interior) begin
                    // Interior reads are strictly sequential, so a running address replaces c*H*W+...
                    rd_en   = 1'b1;
                    addr_n  = addr + ADDR_WIDTH'(1);
                    state_n = S_WAIT;
                end else begin
                    data_n  = '0;
                    valid_n = 1'b1;
                    last_n  = last_pix;
                    state_n = S_HOLD;
                end
            end
            S_WAIT: begin
                data_n  = rd_data;
                valid_n = 1'b1;
                last_n  = last_pix;
                state_n = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    valid_n = 1'b0;
                    last_n  = 1'b0;
                    if (last_pix) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_ISSUE;
                        if (x == X_LAST) begin
                            x_n = '0;
                            if (y == Y_LAST) begin
                                y_n = '0;
                                c_n = c + CCW'(1);
                            end else begin
                                y_n = y + CW'(1);
                            end
                        end else begin
                            x_n = x + CW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            c         <= '0;
            y         <= '0;
            x         <= '0;
            addr      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_n;
            c         <= c_n;
            y         <= y_n;
            x         <= x_n;
            addr      <= addr_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            out_last  <= last_n;
        end
    end

endmodule

// File: tb/tb_padding_stream_ctrl.sv
// Bench for padding_stream_ctrl: three instances (default, D=2, P=0 3x3) share one clock,
// and a selector routes the scenario under test to a common driver and scoreboard.
module tb_padding_stream_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        ready;
    logic [1:0]  sel;
    int          mem_mode;

    logic        st   [3];
    logic        bz   [3];
    logic        dn   [3];
    logic        rde  [3];
    logic [15:0] ra   [3];
    logic [15:0] rdd  [3];
    logic        ov   [3];
    logic [15:0] od   [3];
    logic        ol   [3];
    logic [2:0]  dbg  [3];

    logic        m_busy, m_done, m_rd_en, m_valid, m_last;
    logic [15:0] m_rd_addr, m_data;

    int pd_d [3] = '{1, 2, 1};
    int pd_h [3] = '{10, 10, 3};
    int pd_w [3] = '{10, 10, 3};
    int pd_p [3] = '{2, 2, 0};

    logic [16:0] exp_q[$];
    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    padding_stream_ctrl u0 (
        .clk(clk), .rst(rst), .start(st[0]), .busy(bz[0]), .done(dn[0]),
        .rd_en(rde[0]), .rd_addr(ra[0]), .rd_data(rdd[0]), .out_valid(ov[0]),
        .out_ready(ready), .out_data(od[0]), .out_last(ol[0]), .dbg_state(dbg[0])
    );

    padding_stream_ctrl #(.D(2)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .busy(bz[1]), .done(dn[1]),
        .rd_en(rde[1]), .rd_addr(ra[1]), .rd_data(rdd[1]), .out_valid(ov[1]),
        .out_ready(ready), .out_data(od[1]), .out_last(ol[1]), .dbg_state(dbg[1])
    );

    padding_stream_ctrl #(.H(3), .W(3), .P(0)) u2 (
        .clk(clk), .rst(rst), .start(st[2]), .busy(bz[2]), .done(dn[2]),
        .rd_en(rde[2]), .rd_addr(ra[2]), .rd_data(rdd[2]), .out_valid(ov[2]),
        .out_ready(ready), .out_data(od[2]), .out_last(ol[2]), .dbg_state(dbg[2])
    );

    function automatic logic [15:0] mem_val(input int a);
        case (mem_mode)
            1:       return 16'(a);
            2:       return 16'(a + 1);
            default: return 16'h4444;
        endcase
    endfunction

    // Synchronous buffer model; garbage when not reading so early/late captures show up.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            rdd[i] <= rde[i] ? mem_val(int'(ra[i])) : 16'hDEAD;
    end

    always_comb begin
        for (int i = 0; i < 3; i++) st[i] = start && (sel == 2'(i));
        m_busy    = bz[sel];
        m_done    = dn[sel];
        m_rd_en   = rde[sel];
        m_rd_addr = ra[sel];
        m_valid   = ov[sel];
        m_data    = od[sel];
        m_last    = ol[sel];
    end

    // Reference walk of the padded volume, addresses from the closed-form formula.
    task automatic push_frame(input int s);
        int dd, hh, ww, pp, hp, wp;
        logic [15:0] v;
        logic l;
        dd = pd_d[s]; hh = pd_h[s]; ww = pd_w[s]; pp = pd_p[s];
        hp = hh + 2 * pp; wp = ww + 2 * pp;
        for (int c = 0; c < dd; c++)
            for (int y = 0; y < hp; y++)
                for (int x = 0; x < wp; x++) begin
                    if (y >= pp && y < pp + hh && x >= pp && x < pp + ww)
                        v = mem_val(c * hh * ww + (y - pp) * ww + (x - pp));
                    else
                        v = 16'h0000;
                    l = (c == dd - 1) && (y == hp - 1) && (x == wp - 1);
                    exp_q.push_back({l, v});
                end
    endtask

    task automatic run_frame(input int s, input bit rnd, input bit poke_start, input int abort_beat,
                             output int beats, output int reads, output int dones,
                             output int lasts, output int nz, output int first_nz);
        int acc_cyc, exp_addr;
        bit stall, finished;
        logic [15:0] prev_d;
        logic prev_l;
        logic [16:0] e;
        beats = 0; reads = 0; dones = 0; lasts = 0; nz = 0; first_nz = -1;
        acc_cyc = -10; exp_addr = 0; stall = 1'b0; finished = 1'b0;
        prev_d = '0; prev_l = 1'b0;
        sel = 2'(s);
        push_frame(s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (m_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got %b want 1", m_busy);
        end
        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            if (m_rd_en) begin
                checks++;
                if (m_rd_addr !== 16'(exp_addr)) begin
                    errors++;
                    $display("FAIL rd_addr got %0d want %0d", m_rd_addr, exp_addr);
                end
                exp_addr++;
                reads++;
            end
            if (stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_d || m_last !== prev_l) begin
                    errors++;
                    $display("FAIL hold_stable got v=%b %h/%b want v=1 %h/%b",
                             m_valid, m_data, m_last, prev_d, prev_l);
                end
            end
            if (m_done) begin
                dones++;
                checks++;
                if (cyc != acc_cyc + 1) begin
                    errors++;
                    $display("FAIL done_timing got cycle %0d want %0d", cyc, acc_cyc + 1);
                end
                if (poke_start) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                checks++;
                if (m_busy !== 1'b0 || m_done !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_after_done got busy=%b done=%b want 0 0", m_busy, m_done);
                end
                finished = 1'b1;
            end else begin
                ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (m_valid && ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_extra got %h/%b want no beat", m_data, m_last);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_last, m_data} !== e) begin
                            errors++;
                            $display("FAIL beat_%0d got %h/%b want %h/%b",
                                     beats, m_data, m_last, e[15:0], e[16]);
                        end
                    end
                    if (m_last) lasts++;
                    if (m_data != 16'h0000) begin
                        nz++;
                        if (first_nz < 0) first_nz = beats;
                    end
                    beats++;
                    acc_cyc = cyc;
                    if (poke_start && beats == 50) start = 1'b1;
                end
                stall  = m_valid && !ready;
                prev_d = m_data;
                prev_l = m_last;
                @(posedge clk); #1;
                start = 1'b0;
                if (abort_beat != 0 && beats == abort_beat) finished = 1'b1;
            end
        end
        ready = 1'b1;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL frame_timeout got %0d beats want frame end", beats);
        end
        if (abort_beat == 0) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL beats_missing got %0d left want 0", exp_q.size());
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; ready = 1'b1; sel = 2'd0; mem_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bz[i], dn[i], rde[i], ov[i], ol[i], ra[i], od[i], dbg[i]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs_%0d got b%b d%b r%b v%b l%b a%h o%h s%0d want all 0",
                         i, bz[i], dn[i], rde[i], ov[i], ol[i], ra[i], od[i], dbg[i]);
            end
        end
        // start presented while reset is still low at the edge must be dropped
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_reset got busy=%b want 0", m_busy);
        end
    endtask

    task automatic test_border_fill();
        int b, r, d, l, nz, fnz;
        mem_mode = 0;
        run_frame(0, 1'b0, 1'b0, 0, b, r, d, l, nz, fnz);
        checks++;
        if (b != 196 || r != 100 || d != 1 || l != 1 || nz != 100 || fnz != 30) begin
            errors++;
            $display("FAIL border_fill got beats=%0d reads=%0d done=%0d last=%0d nz=%0d first=%0d want 196 100 1 1 100 30",
                     b, r, d, l, nz, fnz);
        end
    endtask

    task automatic test_backpressure();
        int b, r, d, l, nz, fnz;
        mem_mode = 0;
        run_frame(0, 1'b1, 1'b0, 0, b, r, d, l, nz, fnz);
        checks++;
        if (b != 196 || r != 100 || d != 1 || l != 1) begin
            errors++;
            $display("FAIL backpressure got beats=%0d reads=%0d done=%0d last=%0d want 196 100 1 1",
                     b, r, d, l);
        end
    endtask

    task automatic test_two_channels();
        int b, r, d, l, nz, fnz;
        mem_mode = 1;
        run_frame(1, 1'b0, 1'b0, 0, b, r, d, l, nz, fnz);
        checks++;
        if (b != 392 || r != 200 || d != 1 || l != 1) begin
            errors++;
            $display("FAIL two_channels got beats=%0d reads=%0d done=%0d last=%0d want 392 200 1 1",
                     b, r, d, l);
        end
    endtask

    task automatic test_restart_ignored();
        int b, r, d, l, nz, fnz;
        mem_mode = 0;
        run_frame(0, 1'b0, 1'b1, 0, b, r, d, l, nz, fnz);
        checks++;
        if (b != 196 || d != 1 || r != 100) begin
            errors++;
            $display("FAIL restart_ignored got beats=%0d done=%0d reads=%0d want 196 1 100", b, d, r);
        end
    endtask

    task automatic test_mid_reset();
        int b, r, d, l, nz, fnz;
        bit quiet;
        mem_mode = 1;
        run_frame(0, 1'b0, 1'b0, 80, b, r, d, l, nz, fnz);
        rst = 1'b0;
        #1;
        checks++;
        if ({m_busy, m_done, m_rd_en, m_valid, m_last, m_rd_addr, m_data} !== '0) begin
            errors++;
            $display("FAIL async_reset got b%b d%b r%b v%b l%b a%h o%h want all 0",
                     m_busy, m_done, m_rd_en, m_valid, m_last, m_rd_addr, m_data);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (m_valid || m_busy || m_done || m_rd_en) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL abandoned_frame got activity after reset want none");
        end
        mem_mode = 2;
        run_frame(0, 1'b1, 1'b0, 0, b, r, d, l, nz, fnz);
        checks++;
        if (b != 196 || r != 100 || d != 1 || fnz != 30) begin
            errors++;
            $display("FAIL after_reset got beats=%0d reads=%0d done=%0d first=%0d want 196 100 1 30",
                     b, r, d, fnz);
        end
    endtask

    task automatic test_no_pad();
        int b, r, d, l, nz, fnz;
        mem_mode = 2;
        run_frame(2, 1'b0, 1'b0, 0, b, r, d, l, nz, fnz);
        checks++;
        if (b != 9 || r != 9 || nz != 9 || l != 1 || d != 1) begin
            errors++;
            $display("FAIL no_pad got beats=%0d reads=%0d nz=%0d last=%0d done=%0d want 9 9 9 1 1",
                     b, r, nz, l, d);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_border_fill();
        test_backpressure();
        test_two_channels();
        test_restart_ignored();
        test_mid_reset();
        test_no_pad();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
